// File: rtl/prf_wb_arbiter.sv
// rtl/prf_wb_arbiter.sv - round-robin merge of FU completion streams onto the single PRF writeback port.
// Each FU feeds a 2-entry skid FIFO; a flush squashes everything buffered and counts the discards.
module prf_wb_arbiter #(
  parameter int FU_NUM    = 4,
  parameter int PHYS_REGS = 64,
  parameter int PHYS_W    = $clog2(PHYS_REGS),
  parameter int DW        = 32,
  parameter int EPOCH_W   = 2,
  parameter int CNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FU_NUM-1:0]                 fu_valid,
  output logic [FU_NUM-1:0]                 fu_ready,
  input  logic [FU_NUM-1:0][PHYS_W-1:0]     fu_pd,
  input  logic [FU_NUM-1:0][DW-1:0]         fu_data,
  input  logic [FU_NUM-1:0][EPOCH_W-1:0]    fu_epoch,
  input  logic [EPOCH_W-1:0]                cur_epoch,
  input  logic                              flush_valid,
  output logic                              wb_valid,
  input  logic                              wb_ready,
  output logic [PHYS_W-1:0]                 wb_pd,
  output logic [DW-1:0]                     wb_data,
  output logic [EPOCH_W-1:0]                wb_epoch,
  output logic [$clog2(FU_NUM)-1:0]         grant_idx,
  output logic [CNT_W-1:0]                  drop_count
);
  localparam int IDX_W = $clog2(FU_NUM);

  logic [1:0]          cnt_q    [FU_NUM];
  logic [FU_NUM-1:0]   wr_ptr_q;
  logic [FU_NUM-1:0]   rd_ptr_q;
  logic [PHYS_W-1:0]   pd_mem   [FU_NUM][2];
  logic [DW-1:0]       data_mem [FU_NUM][2];
  logic [EPOCH_W-1:0]  ep_mem   [FU_NUM][2];
  logic [IDX_W-1:0]    rr_ptr;

  logic [FU_NUM-1:0]   push_hs;
  logic [FU_NUM-1:0]   accept;
  logic [FU_NUM-1:0]   pop;
  logic                found;
  logic [IDX_W-1:0]    gnt;
  logic [IDX_W-1:0]    rr_next;
  logic                load;
  int                  idx;
  int                  drop_inc;
  logic [CNT_W:0]      drop_sum;
  logic [CNT_W-1:0]    drop_next;

  // No pass-through when full: readiness depends on stored occupancy only.
  always_comb begin
    fu_ready = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      fu_ready[i] = (cnt_q[i] != 2'd2);
    end
  end

  always_comb begin
    push_hs = fu_valid & fu_ready;
    accept  = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      accept[i] = push_hs[i] && (fu_epoch[i] == cur_epoch) && !flush_valid;
    end

    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < FU_NUM; k++) begin
      idx = (int'(rr_ptr) + k) % FU_NUM;
      if (!found && cnt_q[idx] != 2'd0) begin
        found = 1'b1;
        gnt   = IDX_W'(idx);
      end
    end
    rr_next = (gnt == IDX_W'(FU_NUM - 1)) ? '0 : gnt + 1'b1;

    load = (!wb_valid || wb_ready) && found && !flush_valid;
    pop  = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      pop[i] = load && (gnt == IDX_W'(i));
    end

    // On flush every buffered entry, the unconsumed output and every handshaken input is lost.
    drop_inc = 0;
    if (flush_valid) begin
      for (int i = 0; i < FU_NUM; i++) begin
        drop_inc = drop_inc + int'(cnt_q[i]) + (push_hs[i] ? 1 : 0);
      end
      drop_inc = drop_inc + ((wb_valid && !wb_ready) ? 1 : 0);
    end else begin
      for (int i = 0; i < FU_NUM; i++) begin
        drop_inc = drop_inc + ((push_hs[i] && !accept[i]) ? 1 : 0);
      end
    end
    drop_sum  = {1'b0, drop_count} + (CNT_W+1)'(drop_inc);
    drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FU_NUM; i++) begin
        cnt_q[i] <= 2'd0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wb_valid   <= 1'b0;
      wb_pd      <= '0;
      wb_data    <= '0;
      wb_epoch   <= '0;
      grant_idx  <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      drop_count <= drop_next;
      for (int i = 0; i < FU_NUM; i++) begin
        if (flush_valid) begin
          cnt_q[i]    <= 2'd0;
          wr_ptr_q[i] <= 1'b0;
          rd_ptr_q[i] <= 1'b0;
        end else begin
          if (accept[i]) wr_ptr_q[i] <= ~wr_ptr_q[i];
          if (pop[i])    rd_ptr_q[i] <= ~rd_ptr_q[i];
          cnt_q[i] <= cnt_q[i] + {1'b0, accept[i]} - {1'b0, pop[i]};
        end
      end
      if (flush_valid) begin
        wb_valid <= 1'b0;
      end else if (load) begin
        wb_valid  <= 1'b1;
        wb_pd     <= pd_mem[gnt][rd_ptr_q[gnt]];
        wb_data   <= data_mem[gnt][rd_ptr_q[gnt]];
        wb_epoch  <= ep_mem[gnt][rd_ptr_q[gnt]];
        grant_idx <= gnt;
        rr_ptr    <= rr_next;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_NUM; i++) begin
      if (accept[i]) begin
        pd_mem[i][wr_ptr_q[i]]   <= fu_pd[i];
        data_mem[i][wr_ptr_q[i]] <= fu_data[i];
        ep_mem[i][wr_ptr_q[i]]   <= fu_epoch[i];
      end
    end
  end
endmodule
